config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Sequences the serial configuration chain of a tile column (IO and logic tile config shift registers daisy-chained config_out to config_in).
- Accepts bitstream words from the host over a valid/ready handshake and serialises them into the chain one bit per clock, driving chain enable.
- Stops after exactly CHAIN_LENGTH bits.
- Sits between the bitstream port and the first tile of the chain; the chain is clocked on the same clock.

Parameters:
- CHAIN_LENGTH, 24, total config bits in the chain (sum of all tile config widths).
- WORD_WIDTH, 8, bitstream word width from the host.

Ports:
- clock  input  1  single clock for the block and the config chain
- nreset  input  1  asynchronous active-low reset
- start  input  1  begin a load; sampled only in IDLE
- abort  input  1  cancel an in-progress load
- word_data  input  WORD_WIDTH  bitstream word, LSB shifted first
- word_valid  input  1  word_data valid
- word_ready  output  1  block accepts word this cycle
- chain_data  output  1  serial bit to first tile config_in
- chain_enable  output  1  shift enable to every tile in the chain
- chain_return  input  1  config_out of last tile in the chain
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a load finishes
- error  output  1  sticky; cleared on accepted start

Behaviour:
- Reset (async, nreset low):
  - State goes to IDLE.
  - chain_data=0, chain_enable=0, word_ready=0, busy=0, done=0, error=0.
  - Bit counter and word buffer cleared.
  - Chain contents after reset are undefined and not restored.
- States: IDLE, LOAD, VERIFY (optional), FINISH.
- IDLE:
  - start=1 moves to LOAD next cycle, clears error and the bit counter (width $clog2(CHAIN_LENGTH+1)).
- LOAD:
  - Single-entry word buffer with a bit index 0..WORD_WIDTH-1.
  - word_ready is combinational: 1 when the buffer is empty, or when the buffer's final bit (index WORD_WIDTH-1) is being shifted this cycle. This gives gapless streaming.
  - word_valid & word_ready loads the buffer.
  - Each cycle the buffer holds a bit: chain_data = current bit, chain_enable=1, bit counter +1, bit index +1.
  - Buffer empty and no word present: chain_enable=0 (stall); no bit is lost or duplicated.
  - When the counter reaches CHAIN_LENGTH:
    - word_ready=0 from that cycle.
    - Any unshifted bits left in the current word are discarded.
    - Go to VERIFY if the optional feature is enabled, else FINISH.
  - With continuous valid: chain_enable is high for exactly CHAIN_LENGTH consecutive cycles and ceil(CHAIN_LENGTH/WORD_WIDTH) words are accepted.
- FINISH:
  - One cycle; done=1; return to IDLE.
  - Latency: done is asserted the cycle after the last chain_enable.
- abort in LOAD or VERIFY:
  - Next cycle: IDLE, chain_enable=0, error=1, no done pulse.
  - abort in IDLE is ignored.
- start while busy: ignored.
- start and abort simultaneously in IDLE: start wins.
- chain_enable is never high in IDLE or FINISH.

Optional Feature:
- Macro: CONFIG_CHAIN_LOADER_VERIFY_EN.
- Defined:
  - During LOAD, a bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) is accumulated over every shifted bit.
  - After LOAD the block enters VERIFY: for CHAIN_LENGTH cycles, chain_enable=1 and chain_data=chain_return. This recirculates the chain, restoring its contents.
  - A second CRC over chain_return accumulates in the same order.
  - At the end of VERIFY: CRCs compare; on mismatch error=1. Then FINISH (done pulses regardless).
  - Total chain_enable cycles = 2*CHAIN_LENGTH.
- Undefined: no CRC logic, no VERIFY state; LOAD goes directly to FINISH; error is set only by abort.

Test Plan:
- Basic load (CHAIN_LENGTH=24, WORD_WIDTH=8): start, then words 0xA5, 0x3C, 0xFF with valid held high.
  - chain_enable high for 24 consecutive cycles.
  - chain_data sequence begins 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 then eight 1s.
  - Exactly 3 word_ready&valid handshakes.
  - done pulses one cycle after the last enable.
- Partial final word (CHAIN_LENGTH=20): feed 0x00, 0x00, 0xFF.
  - chain_enable high for exactly 20 cycles.
  - Last 4 chain_data bits are 1; the top 4 bits of 0xFF are never driven.
  - word_ready=0 after the 3rd word.
- Stall: deassert word_valid for 5 cycles after the first word.
  - chain_enable low for those 5 cycles.
  - Shifted bit stream identical to the unstalled case; total enables still 24.
- Abort: assert abort after 10 shifted bits.
  - Next cycle busy=0, chain_enable=0, error=1, no done.
  - A new start clears error and completes normally.
- Reset mid-load: drop nreset after 12 bits.
  - All outputs 0 immediately (async).
  - After release, start performs a full 24-bit load.
- VERIFY_EN with a 24-stage shift register model on chain_data/chain_return:
  - 48 enable cycles, error=0, done pulses.
  - Model contents after done equal the loaded bitstream.
  - Forcing one chain_return bit wrong during VERIFY gives error=1.

Source files
------------

// File: rtl/config_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// config_chain_loader: serialises host bitstream words (LSB first) into a tile-column config chain.
// Define CONFIG_CHAIN_LOADER_VERIFY_EN to add CRC-checked recirculation of the chain after loading.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 24,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  input  logic                  chain_return,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd3;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  error_q, error_d;

  logic shift, buf_last, last_shift, accept;

  assign shift      = (state_q == S_LOAD) && buf_vld_q;
  assign buf_last   = (idx_q == LAST_IDX);
  assign last_shift = shift && (cnt_q == LAST_BIT);
  // Ready during the final bit of a word keeps the stream gapless; never once the chain is full.
  assign word_ready = (state_q == S_LOAD) && !last_shift && (!buf_vld_q || buf_last);
  assign accept     = word_valid && word_ready;

`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
  logic [15:0] crc_load_q, crc_load_d, crc_ret_q, crc_ret_d;
  logic        verify;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
  endfunction

  assign verify       = (state_q == S_VERIFY);
  assign chain_enable = shift || verify;
  assign chain_data   = shift ? buf_q[idx_q] : (verify & chain_return);
`else
  logic unused_chain_return;
  assign unused_chain_return = chain_return;
  assign chain_enable = shift;
  assign chain_data   = shift & buf_q[idx_q];
`endif

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_FINISH);
  assign error = error_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    idx_d     = idx_q;
    error_d   = error_q;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
    crc_load_d = crc_load_q;
    crc_ret_d  = crc_ret_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          buf_vld_d = 1'b0;
          idx_d     = '0;
          error_d   = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
          crc_load_d = 16'hFFFF;
          crc_ret_d  = 16'hFFFF;
`endif
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          buf_vld_d = 1'b0;
          error_d   = 1'b1;
        end else begin
          if (shift) begin
            cnt_d = cnt_q + 1'b1;
            idx_d = buf_last ? '0 : idx_q + 1'b1;
            if (buf_last) buf_vld_d = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
            crc_load_d = crc_step(crc_load_q, chain_data);
`endif
          end
          if (accept) begin
            buf_d     = word_data;
            buf_vld_d = 1'b1;
            idx_d     = '0;
          end
          // Chain full: leftover bits of the current word are dropped.
          if (last_shift) begin
            buf_vld_d = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
            state_d = S_VERIFY;
            cnt_d   = '0;
`else
            state_d = S_FINISH;
`endif
          end
        end
      end
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (abort) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          crc_ret_d = crc_step(crc_ret_q, chain_return);
          if (cnt_q == LAST_BIT) begin
            state_d = S_FINISH;
            if (crc_ret_d != crc_load_q) error_d = 1'b1;
          end
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      idx_q     <= '0;
      error_q   <= 1'b0;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
      crc_load_q <= 16'hFFFF;
      crc_ret_q  <= 16'hFFFF;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      idx_q     <= idx_d;
      error_q   <= error_d;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
      crc_load_q <= crc_load_d;
      crc_ret_q  <= crc_ret_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// tb_config_chain_loader: randomized self-checking bench with a bitstream/chain reference model.
module tb_config_chain_loader;

  localparam int L  = 24;
  localparam int L2 = 20;
  localparam int W  = 8;
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic nreset = 1'b0;
  logic start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [W-1:0] word_data = '0;
  logic word_ready, chain_data, chain_enable, chain_return, busy, done, error;

  logic b_start = 1'b0, b_abort = 1'b0, b_word_valid = 1'b0;
  logic [W-1:0] b_word_data = '0;
  logic b_word_ready, b_chain_data, b_chain_enable, b_chain_return, b_busy, b_done, b_error;

  config_chain_loader #(.CHAIN_LENGTH(L), .WORD_WIDTH(W)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .chain_data(chain_data), .chain_enable(chain_enable), .chain_return(chain_return),
    .busy(busy), .done(done), .error(error)
  );

  config_chain_loader #(.CHAIN_LENGTH(L2), .WORD_WIDTH(W)) dut20 (
    .clock(clock), .nreset(nreset), .start(b_start), .abort(b_abort),
    .word_data(b_word_data), .word_valid(b_word_valid), .word_ready(b_word_ready),
    .chain_data(b_chain_data), .chain_enable(b_chain_enable), .chain_return(b_chain_return),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  // Tile-chain models: plain shift registers clocked by chain_enable.
  logic [L-1:0]  chain_q   = '0;
  logic [L2-1:0] chain20_q = '0;
  logic          flip_ret  = 1'b0;
  assign chain_return   = chain_q[L-1] ^ flip_ret;
  assign b_chain_return = chain20_q[L2-1];
  always @(posedge clock) begin
    if (chain_enable)   chain_q   <= {chain_q[L-2:0], chain_data};
    if (b_chain_enable) chain20_q <= {chain20_q[L2-2:0], b_chain_data};
  end

  int checks = 0, failures = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = -1;
  bit bits_q[$];
  int en_cyc_q[$];
  int b_cyc = 0, b_hs = 0, b_done_cnt = 0, b_done_cyc = -1, b_last_en = -1;
  bit b_bits[$];
  logic [W-1:0] words_q[$];
  bit exp_q[$];

  always @(negedge clock) begin
    cyc++;
    if (chain_enable) begin
      bits_q.push_back(chain_data);
      en_cyc_q.push_back(cyc);
    end
    if (word_valid && word_ready) hs_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(negedge clock) begin
    b_cyc++;
    if (b_chain_enable) begin
      b_bits.push_back(b_chain_data);
      b_last_en = b_cyc;
    end
    if (b_word_valid && b_word_ready) b_hs++;
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = b_cyc;
    end
  end

  // Expected stream: words concatenated LSB first, truncated to the chain length.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] wv;
      wv = words_q[i / W];
      exp_q.push_back(wv[i % W]);
    end
  endtask

  task automatic random_words();
    words_q.delete();
    for (int i = 0; i < (L + W - 1) / W; i++) words_q.push_back(W'($urandom));
  endtask

  task automatic do_load(input int gap_max, input int second_gap, input bit with_abort);
    int t, gap, d0;
    d0 = done_cnt;
    start = 1'b1;
    abort = with_abort;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    if (with_abort) begin
      checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
        failures++;
        $display("FAIL start_with_abort: busy=%0b error=%0b, want busy=1 error=0", busy, error);
      end
    end
    for (int w = 0; w < (L + W - 1) / W; w++) begin
      gap = (w == 1 && second_gap >= 0) ? second_gap : int'($urandom_range(gap_max, 0));
      repeat (gap) begin
        word_valid = 1'b0;
        @(posedge clock); #1;
      end
      word_valid = 1'b1;
      word_data  = words_q[w];
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!word_ready && t < 200);
      @(posedge clock); #1;
    end
    word_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 1000) begin
      @(posedge clock);
      t++;
    end
    #1;
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL load_timeout: done_count=%0d, want %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic check_load(input string name, input int bb, input int hb, input int db, input int exp_stall);
    int n, mism, span;
    n = bits_q.size() - bb;
    checks++;
    if (n !== PASSES * L) begin
      failures++;
      $display("FAIL %s_enables: got %0d, want %0d", name, n, PASSES * L);
    end
    mism = 0;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < L; i++)
        if (bb + p * L + i >= bits_q.size() || bits_q[bb + p * L + i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL %s_stream: %0d wrong bits, want 0", name, mism);
    end
    checks++;
    if (hs_cnt - hb !== (L + W - 1) / W) begin
      failures++;
      $display("FAIL %s_handshakes: got %0d, want %0d", name, hs_cnt - hb, (L + W - 1) / W);
    end
    checks++;
    if (done_cnt - db !== 1 || en_cyc_q.size() == 0 || done_cyc !== en_cyc_q[en_cyc_q.size() - 1] + 1) begin
      failures++;
      $display("FAIL %s_done: pulses=%0d at cycle %0d, want 1 pulse one cycle after last enable", name, done_cnt - db, done_cyc);
    end
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_status: error=%0b busy=%0b, want 0 0", name, error, busy);
    end
    mism = 0;
    for (int i = 0; i < L; i++) if (chain_q[L - 1 - i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL %s_chain_contents: %0d wrong bits, want 0", name, mism);
    end
    if (exp_stall >= 0 && n >= L) begin
      span = en_cyc_q[bb + L - 1] - en_cyc_q[bb] + 1 - L;
      checks++;
      if (span !== exp_stall) begin
        failures++;
        $display("FAIL %s_stall_cycles: got %0d, want %0d", name, span, exp_stall);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({word_ready, chain_data, chain_enable, busy, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, want 000000", {word_ready, chain_data, chain_enable, busy, done, error});
    end
    checks++;
    if ({b_word_ready, b_chain_data, b_chain_enable, b_busy, b_done, b_error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs20: got %b, want 000000", {b_word_ready, b_chain_data, b_chain_enable, b_busy, b_done, b_error});
    end
    #2 nreset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({word_ready, chain_enable, busy, done, error} !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b, want 00000", {word_ready, chain_enable, busy, done, error});
    end
  endtask

  task automatic test_basic();
    int bb = bits_q.size(), hb = hs_cnt, db = done_cnt;
    words_q = {8'hA5, 8'h3C, 8'hFF};
    build_exp();
    do_load(0, -1, 1'b0);
    check_load("basic", bb, hb, db, 0);
  endtask

  task automatic test_stall();
    int bb = bits_q.size(), hb = hs_cnt, db = done_cnt;
    random_words();
    build_exp();
    // 8 cycles to drain the first word plus 5 empty-buffer cycles.
    do_load(0, 12, 1'b0);
    check_load("stall", bb, hb, db, 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int bb = bits_q.size(), hb = hs_cnt, db = done_cnt;
      random_words();
      build_exp();
      do_load(3, -1, 1'b0);
      check_load("random", bb, hb, db, -1);
    end
  endtask

  task automatic test_abort();
    int bb = bits_q.size(), db = done_cnt, t = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    word_valid = 1'b1;
    word_data = W'($urandom);
    while (bits_q.size() - bb < 10 && t < 200) begin
      @(posedge clock);
      t++;
    end
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    word_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || chain_enable !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL abort_state: busy=%0b enable=%0b error=%0b, want 0 0 1", busy, chain_enable, error);
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_cnt !== db || error !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_done: done pulses=%0d error=%0b, want 0 1", done_cnt - db, error);
    end
    begin
      int bb2 = bits_q.size(), hb2 = hs_cnt, db2 = done_cnt;
      random_words();
      build_exp();
      do_load(1, -1, 1'b1);
      check_load("after_abort", bb2, hb2, db2, -1);
    end
  endtask

  task automatic test_idle_abort();
    int db = done_cnt;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || error !== 1'b0 || done_cnt !== db) begin
      failures++;
      $display("FAIL idle_abort: busy=%0b error=%0b dones=%0d, want 0 0 0", busy, error, done_cnt - db);
    end
  endtask

  task automatic test_reset_midload();
    int bb = bits_q.size(), t = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    word_valid = 1'b1;
    word_data = W'($urandom);
    while (bits_q.size() - bb < 12 && t < 200) begin
      @(posedge clock);
      t++;
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({word_ready, chain_data, chain_enable, busy, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset: got %b, want 000000", {word_ready, chain_data, chain_enable, busy, done, error});
    end
    word_valid = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b1;
    @(posedge clock); #1;
    begin
      int bb2 = bits_q.size(), hb2 = hs_cnt, db2 = done_cnt;
      random_words();
      build_exp();
      do_load(0, -1, 1'b0);
      check_load("after_reset", bb2, hb2, db2, 0);
    end
  endtask

  task automatic test_partial();
    logic [W-1:0] pw[3];
    int bb = b_bits.size(), hb = b_hs, db = b_done_cnt, t, mism;
    pw = '{8'h00, 8'h00, 8'hFF};
    b_start = 1'b1;
    @(posedge clock); #1;
    b_start = 1'b0;
    b_word_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      b_word_data = pw[w];
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!b_word_ready && t < 200);
      @(posedge clock); #1;
    end
    t = 0;
    while (b_done_cnt == db && t < 500) begin
      @(posedge clock);
      t++;
    end
    #1 b_word_valid = 1'b0;
    checks++;
    if (b_bits.size() - bb !== PASSES * L2) begin
      failures++;
      $display("FAIL partial_enables: got %0d, want %0d", b_bits.size() - bb, PASSES * L2);
    end
    mism = 0;
    for (int i = 0; i < L2; i++)
      if (bb + i >= b_bits.size() || b_bits[bb + i] !== (i >= 16)) mism++;
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL partial_stream: %0d wrong bits, want 0", mism);
    end
    checks++;
    if (b_hs - hb !== 3) begin
      failures++;
      $display("FAIL partial_handshakes: got %0d, want 3", b_hs - hb);
    end
    checks++;
    if (b_done_cnt - db !== 1 || b_done_cyc !== b_last_en + 1 || b_error !== 1'b0) begin
      failures++;
      $display("FAIL partial_done: pulses=%0d latency=%0d error=%0b, want 1 1 0", b_done_cnt - db, b_done_cyc - b_last_en, b_error);
    end
  endtask

`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
  task automatic test_verify_error();
    int bb = bits_q.size(), db = done_cnt;
    random_words();
    build_exp();
    fork
      do_load(0, -1, 1'b0);
      begin
        int t = 0;
        while (bits_q.size() < bb + L + 5 && t < 500) begin
          @(posedge clock);
          t++;
        end
        #1 flip_ret = 1'b1;
        @(posedge clock); #1;
        flip_ret = 1'b0;
      end
    join
    checks++;
    if (error !== 1'b1 || done_cnt - db !== 1 || bits_q.size() - bb !== 2 * L) begin
      failures++;
      $display("FAIL verify_error: error=%0b dones=%0d enables=%0d, want 1 1 %0d", error, done_cnt - db, bits_q.size() - bb, 2 * L);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_abort();
    test_idle_abort();
    test_reset_midload();
    test_partial();
`ifdef CONFIG_CHAIN_LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
